fir_ctrl: RTL
=============

Name: fir_ctrl

Overview:
- Sequencer and configuration controller for the 9-tap pipelined FIR datapath (16-bit signed samples and coefficients, 6-cycle sample-to-output latency).
- Owns the coefficient register file, which is double-buffered as a shadow bank and an active bank.
- Gates sample entry into the datapath and produces an output-valid strobe aligned with filtered_signal.
- Performs safe coefficient swaps: stop input, drain the pipeline, swap banks, flush the delay line, resume.

Parameters:
- NTAPS, 9: number of taps/coefficients.
- CW, 16: coefficient width (signed).
- LATENCY, 6: cycles from accepted sample to the corresponding datapath output.
- AW, 4: cfg_addr width; must satisfy 2**AW >= NTAPS.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  source has a sample this cycle.
- in_ready  out  1  controller accepts a sample this cycle.
- dp_en  out  1  datapath delay-line shift enable; equals in_valid & in_ready.
- dp_flush  out  1  one-cycle pulse; the datapath clears its delay line and pipeline registers.
- out_valid  out  1  filtered_signal is valid this cycle.
- cfg_valid  in  1  coefficient write request.
- cfg_ready  out  1  write/commit accepted this cycle.
- cfg_addr  in  AW  tap index of the write.
- cfg_data  in  CW  signed coefficient value.
- cfg_commit  in  1  request swap of shadow into active; sampled only while cfg_ready=1.
- cfg_err  out  1  one-cycle pulse when an accepted write has cfg_addr >= NTAPS.
- coeff_flat  out  NTAPS*CW  active coefficients, tap k at bits [k*CW +: CW].
- busy  out  1  high in DRAIN and SWAP.

Behaviour:
- Reset (async assert, sync release):
  - Active and shadow banks both load {04F6, 0AE4, 1089, 1496, 160F, 1496, 1089, 0AE4, 04F6}.
  - Valid shift register cleared; state IDLE.
  - in_ready=1, cfg_ready=1, out_valid=0, dp_flush=0, cfg_err=0, busy=0.
  - Any pending commit is dropped.
- Sample path:
  - fire = in_valid & in_ready.
  - vsr is a LATENCY-bit shift register, shifted every cycle, vsr[0] <= fire.
  - out_valid = vsr[LATENCY-1]. A sample accepted at cycle t gives out_valid=1 at t+LATENCY.
  - Back-to-back accepts give back-to-back out_valid.
- States:
  - IDLE: vsr==0, no commit pending. Goes to RUN on fire. Goes to DRAIN on an accepted commit.
  - RUN: samples in flight. Goes to IDLE when vsr becomes 0 and there is no fire. Goes to DRAIN on an accepted commit.
  - DRAIN: in_ready=0, cfg_ready=0, busy=1. Goes to SWAP on the first cycle vsr==0 (the last out_valid has already been emitted).
  - SWAP: exactly one cycle. Active bank <= shadow bank; dp_flush=1; in_ready=0; busy=1. Then goes to IDLE.
- in_ready is combinational from state: 1 in IDLE/RUN, 0 in DRAIN/SWAP.
- cfg_ready is 1 in IDLE/RUN, 0 in DRAIN/SWAP.
- Writes:
  - Accepted when cfg_valid & cfg_ready. Shadow[cfg_addr] <= cfg_data.
  - If cfg_addr >= NTAPS: no write, and cfg_err pulses the following cycle.
  - Writes never touch the active bank directly; coeff_flat is unchanged until SWAP.
- Commit: accepted when cfg_commit & cfg_ready. The state registers DRAIN next cycle.
- Simultaneous events:
  - Write and commit in the same cycle: the write is included in the swap.
  - Sample fire in the same cycle as a commit is accepted; it drains normally and produces its out_valid before SWAP.
  - Commit with vsr==0: goes DRAIN for one cycle, then SWAP.
  - cfg_commit while cfg_ready=0 is ignored, not queued.
- Shadow bank persists after SWAP, so a later commit with no intervening writes reloads the same values.
- No arithmetic on coefficients. Widths pass through unchanged; signedness is preserved on coeff_flat.

Decomposition:
- Shared package fir_pkg: NTAPS, CW, LATENCY, the default coefficient array constant, and the state enum (IDLE, RUN, DRAIN, SWAP).
- One natural sub-module: fir_coeff_bank. It holds the shadow and active register arrays, the write port, the swap strobe and the flat output. It is instantiated once, and the FSM plus vsr stay in fir_ctrl.

Test Plan:
1. Reset default:
   - Stimulus: assert rst mid-run with vsr nonzero.
   - Response: out_valid=0 immediately; coeff_flat tap0=04F6 and tap4=160F; in_ready=1 after release.
2. Latency:
   - Stimulus: single fire at cycle 10.
   - Response: out_valid=1 only at cycle 16.
   - Stimulus: 20 consecutive fires.
   - Response: 20 consecutive out_valid starting 6 cycles after the first.
3. Shadow isolation:
   - Stimulus: write addr 4 = 7FFF, no commit.
   - Response: coeff_flat tap4 stays 160F across 50 samples.
4. Commit during traffic:
   - Stimulus: commit in the same cycle as the 5th of continuous fires.
   - Response: in_ready=0 next cycle; exactly 5 out_valid pulses.
   - Response: SWAP one cycle after the last out_valid, with dp_flush=1 for one cycle and tap4=7FFF.
   - Response: in_ready=1 the following cycle.
5. Same-cycle write and commit:
   - Stimulus: write addr 0 = 8000 together with a commit, while IDLE.
   - Response: DRAIN for 1 cycle, then SWAP; tap0=8000.
   - Stimulus: cfg_valid during DRAIN.
   - Response: cfg_ready=0, and shadow is unchanged.
6. Bad address:
   - Stimulus: write addr 9 and addr 15.
   - Response: cfg_err pulses once each, one cycle after acceptance; no bank changes.
   - Stimulus: then commit.
   - Response: coeff_flat equals the prior shadow contents.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants, default coefficients and FSM states for fir_ctrl
package fir_pkg;
    localparam int NTAPS   = 9;
    localparam int CW      = 16;
    localparam int LATENCY = 6;
    localparam int AW      = 4;

    // Tap k sits at element [k]; the set is symmetric, so it reads the same either way.
    localparam logic [NTAPS-1:0][CW-1:0] DEFAULT_COEFFS = {
        16'h04F6, 16'h0AE4, 16'h1089, 16'h1496, 16'h160F,
        16'h1496, 16'h1089, 16'h0AE4, 16'h04F6
    };

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, SWAP} state_t;
endpackage

// File: rtl/fir_coeff_bank.sv
// rtl/fir_coeff_bank.sv - double-buffered coefficient store, shadow written, active swapped in
module fir_coeff_bank
    import fir_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [CW-1:0]         wr_data,
    input  logic                  swap,
    output logic [NTAPS*CW-1:0]   coeff_flat
);
    logic [NTAPS-1:0][CW-1:0] shadow;
    logic [NTAPS-1:0][CW-1:0] active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= DEFAULT_COEFFS;
            active <= DEFAULT_COEFFS;
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                if (wr_en && (wr_addr == AW'(k))) begin
                    shadow[k] <= wr_data;
                end
            end
            if (swap) begin
                active <= shadow;
            end
        end
    end

    assign coeff_flat = active;
endmodule

// File: rtl/fir_ctrl.sv
// rtl/fir_ctrl.sv - FIR sample gating, output-valid tracking and safe coefficient swap sequencer
module fir_ctrl
    import fir_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  dp_en,
    output logic                  dp_flush,
    output logic                  out_valid,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [CW-1:0]         cfg_data,
    input  logic                  cfg_commit,
    output logic                  cfg_err,
    output logic [NTAPS*CW-1:0]   coeff_flat,
    output logic                  busy
);
    state_t               state;
    state_t               state_nxt;
    logic [LATENCY-1:0]   vsr;
    logic                 fire;
    logic                 wr_acc;
    logic                 addr_bad;
    logic                 vsr_empty_next;

    // After this cycle's shift, vsr holds only what is in its low bits plus the new fire.
    assign vsr_empty_next = (vsr[LATENCY-2:0] == '0);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        cfg_ready = 1'b0;
        dp_flush  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready  = 1'b1;
                cfg_ready = 1'b1;
                if (cfg_commit) begin
                    state_nxt = DRAIN;
                end else if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                in_ready  = 1'b1;
                cfg_ready = 1'b1;
                if (cfg_commit) begin
                    state_nxt = DRAIN;
                end else if (vsr_empty_next && !in_valid) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (vsr_empty_next) begin
                    state_nxt = SWAP;
                end
            end
            SWAP: begin
                busy      = 1'b1;
                dp_flush  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fire      = in_valid & in_ready;
    assign dp_en     = fire;
    assign out_valid = vsr[LATENCY-1];
    assign wr_acc    = cfg_valid & cfg_ready;
    assign addr_bad  = (cfg_addr >= AW'(NTAPS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            vsr     <= '0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            vsr     <= {vsr[LATENCY-2:0], fire};
            cfg_err <= wr_acc & addr_bad;
        end
    end

    fir_coeff_bank u_bank (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_acc & ~addr_bad),
        .wr_addr    (cfg_addr),
        .wr_data    (cfg_data),
        .swap       (dp_flush),
        .coeff_flat (coeff_flat)
    );
endmodule
